jump_controller: RTL and testbench
==================================

# jump_controller

Sequencer wrapped around the jump unit in the processor pipeline. It accepts one jump instruction at a time from the decode stage and resolves its type: unconditional (JumpI), jump-if-zero (JumpCI, taken when FlagZ=1) or jump-if-not-zero (JumpCD, taken when FlagZ=0). It stalls fetch/decode while the Z flag is still being produced by an in-flight instruction, then drives PCSource and the latched target for one cycle. After a taken jump it issues a fixed-length flush of the wrong-path stages, and it keeps a saturating count of taken jumps.

## Interface
Parameters:
- PC_WIDTH, 32, width of jump target / PC.
- FLUSH_CYCLES, 2, number of cycles flush is held after a taken jump (legal range 1..15).

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- jump_req  in  1  decode stage holds a jump instruction; held high until jump_ack, or until dropped by an external flush.
- JumpI  in  1  unconditional jump.
- JumpCI  in  1  conditional jump, taken when FlagZ=1.
- JumpCD  in  1  conditional jump, taken when FlagZ=0.
- FlagZ  in  1  architectural zero flag.
- flag_busy  in  1  an in-flight instruction will still write FlagZ; FlagZ is not yet valid.
- target  in  PC_WIDTH  jump target address, valid while jump_req=1.
- PCSource  out  1  1 = PC loads pc_target this cycle.
- pc_target  out  PC_WIDTH  latched jump target.
- stall  out  1  hold IF/ID registers.
- flush  out  1  squash IF/ID wrong-path instructions.
- jump_ack  out  1  one-cycle pulse; the current jump is resolved.
- taken_count  out  16  saturating count of taken jumps.

## Operation
- All outputs are registered Moore outputs of the FSM. States: IDLE, WAIT_FLAG, REDIRECT, NOTTAKEN, FLUSH.
- **Type priority:** JumpI > JumpCI > JumpCD when several are set. With none set, the request is a no-op: go to NOTTAKEN.
- **Capture:** on acceptance in IDLE, latch the decoded type and target. pc_target updates only at acceptance.
- **IDLE**, when jump_req=1:
  - unconditional -> REDIRECT.
  - conditional with flag_busy=0 -> evaluate FlagZ this cycle; taken -> REDIRECT, else NOTTAKEN.
  - conditional with flag_busy=1 -> WAIT_FLAG.
- **WAIT_FLAG:** stall=1.
  - Stay while flag_busy=1.
  - When flag_busy=0, evaluate the FlagZ sampled that same cycle -> REDIRECT or NOTTAKEN.
  - If jump_req drops, go to IDLE with no ack and no redirect. This takes priority over evaluation.
- **REDIRECT:** one cycle with PCSource=1 and jump_ack=1. taken_count increments, saturating at 0xFFFF. Then -> FLUSH.
- **NOTTAKEN:** one cycle with jump_ack=1 and PCSource=0. Then -> IDLE.
- **FLUSH:** flush=1 for exactly FLUSH_CYCLES cycles, counted by a 4-bit down-counter. jump_req is ignored. Then -> IDLE.
- **Requester rule:** drop jump_req the cycle after jump_ack. A request still high in IDLE after NOTTAKEN is treated as a new jump.
- stall=0, PCSource=0 and flush=0 in every state not listed above.

## Timing
- **Reset:** while rst=0, force IDLE immediately, asynchronously.
  - PCSource=0, pc_target=0, stall=0, flush=0, jump_ack=0, taken_count=0, flush counter=0.
  - Reset mid-operation abandons the jump with no ack.
- **Taken, flag free:** jump_req sampled at edge 0 -> PCSource/jump_ack high in cycle 1 -> flush high in cycles 2..1+FLUSH_CYCLES -> IDLE in cycle 2+FLUSH_CYCLES.
- **Not taken, flag free:** jump_ack high in cycle 1; IDLE in cycle 2.
- **Flag busy for k cycles:** stall high for k cycles; the redirect or ack follows one cycle after flag_busy falls.
- **Stall coverage:** stall is not asserted in the acceptance cycle. The decode stage must hold its instruction while jump_req=1, so no additional stall is needed there.
- FlagZ is sampled only in the evaluation cycle; later changes have no effect.
- **Saturation:** at taken_count=0xFFFF, further taken jumps leave it unchanged.

## Test plan
- **Reset then idle:** rst=0 then 1, jump_req=0 -> all outputs 0 and taken_count=0 for 10 cycles.
- **JumpI sweep:** JumpI=1, target=0x40, FlagZ=0 then 1 -> each gives PCSource=1 and pc_target=0x40 one cycle after request, then flush high for 2 cycles; taken_count=2.
- **JumpCI/JumpCD truth table:**
  - JumpCI with FlagZ=1 -> taken.
  - JumpCI with FlagZ=0 -> jump_ack only, PCSource=0.
  - JumpCD with FlagZ=0 -> taken.
  - JumpCD with FlagZ=1 -> not taken.
  - taken_count increments only on the two taken cases.
- **Flag hazard:** JumpCI with flag_busy=1 for 3 cycles and FlagZ=0 until flag_busy falls, then FlagZ=1 -> stall high for exactly 3 cycles, then PCSource=1 in the next cycle.
- **Abort and reset mid-op:**
  - Drop jump_req during WAIT_FLAG -> IDLE, with no jump_ack and no PCSource.
  - Separately, assert rst=0 during FLUSH -> flush=0 immediately and taken_count=0.
- **Priority and saturation:**
  - JumpI=JumpCD=1 with FlagZ=1 -> taken (JumpI wins).
  - Preload taken_count to 0xFFFF via 65535 taken jumps (or force), then one more taken jump -> taken_count stays 0xFFFF.

Source files
------------

// File: rtl/jump_controller_if.sv
// Jump request / redirect bundle between the decode stage and jump_controller.
// The master side is the decode stage; the slave side is the controller.
interface jump_controller_if #(
  parameter int unsigned PC_WIDTH = 32
);
  logic                jump_req;
  logic                JumpI;
  logic                JumpCI;
  logic                JumpCD;
  logic                FlagZ;
  logic                flag_busy;
  logic [PC_WIDTH-1:0] target;
  logic                PCSource;
  logic [PC_WIDTH-1:0] pc_target;
  logic                stall;
  logic                flush;
  logic                jump_ack;
  logic [15:0]         taken_count;

  modport master (
    output jump_req, JumpI, JumpCI, JumpCD, FlagZ, flag_busy, target,
    input  PCSource, pc_target, stall, flush, jump_ack, taken_count
  );

  modport slave (
    input  jump_req, JumpI, JumpCI, JumpCD, FlagZ, flag_busy, target,
    output PCSource, pc_target, stall, flush, jump_ack, taken_count
  );
endinterface

// File: rtl/jump_controller.sv
// Jump sequencer: resolves one jump at a time, stalls on a pending Z flag, redirects the PC,
// flushes wrong-path stages and counts taken jumps. All outputs are registered.
module jump_controller #(
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic               clk,
  input logic               rst,
  jump_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitFlag,
    StRedirect,
    StNotTaken,
    StFlush
  } state_e;

  localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

  state_e              state_q, state_d;
  logic                cond_z_q, cond_z_d;  // Z value that makes the latched conditional taken
  logic [3:0]          cnt_q, cnt_d;
  logic [PC_WIDTH-1:0] tgt_q, tgt_d;
  logic [15:0]         taken_count_q, taken_count_d;
  logic                pcsrc_q, pcsrc_d;
  logic                stall_q, stall_d;
  logic                flush_q, flush_d;
  logic                ack_q, ack_d;

  always_comb begin
    state_d       = state_q;
    cond_z_d      = cond_z_q;
    cnt_d         = cnt_q;
    tgt_d         = tgt_q;
    taken_count_d = taken_count_q;

    unique case (state_q)
      StIdle: begin
        if (bus.jump_req) begin
          tgt_d = bus.target;
          if (bus.JumpI) begin
            state_d = StRedirect;
          end else if (bus.JumpCI || bus.JumpCD) begin
            cond_z_d = bus.JumpCI;
            if (bus.flag_busy) begin
              state_d = StWaitFlag;
            end else begin
              state_d = (bus.FlagZ == bus.JumpCI) ? StRedirect : StNotTaken;
            end
          end else begin
            state_d = StNotTaken;
          end
        end
      end
      StWaitFlag: begin
        // A dropped request wins over a flag that resolves in the same cycle.
        if (!bus.jump_req) begin
          state_d = StIdle;
        end else if (!bus.flag_busy) begin
          state_d = (bus.FlagZ == cond_z_q) ? StRedirect : StNotTaken;
        end
      end
      StRedirect: begin
        state_d = StFlush;
        cnt_d   = FlushLoad;
      end
      StNotTaken: begin
        state_d = StIdle;
      end
      StFlush: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (state_d == StRedirect && taken_count_q != 16'hFFFF) begin
      taken_count_d = taken_count_q + 16'd1;
    end

    pcsrc_d = (state_d == StRedirect);
    ack_d   = (state_d == StRedirect) || (state_d == StNotTaken);
    stall_d = (state_d == StWaitFlag);
    flush_d = (state_d == StFlush);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      cond_z_q      <= 1'b0;
      cnt_q         <= 4'd0;
      tgt_q         <= '0;
      taken_count_q <= 16'd0;
      pcsrc_q       <= 1'b0;
      stall_q       <= 1'b0;
      flush_q       <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cond_z_q      <= cond_z_d;
      cnt_q         <= cnt_d;
      tgt_q         <= tgt_d;
      taken_count_q <= taken_count_d;
      pcsrc_q       <= pcsrc_d;
      stall_q       <= stall_d;
      flush_q       <= flush_d;
      ack_q         <= ack_d;
    end
  end

  assign bus.PCSource    = pcsrc_q;
  assign bus.pc_target   = tgt_q;
  assign bus.stall       = stall_q;
  assign bus.flush       = flush_q;
  assign bus.jump_ack    = ack_q;
  assign bus.taken_count = taken_count_q;

endmodule

// File: tb/tb_jump_controller.sv
// Directed bench for jump_controller: per-cycle expected outputs go through a scoreboard queue
// and are compared one cycle later against the registered outputs.
module tb_jump_controller;

  localparam int unsigned PcW = 32;

  typedef struct {
    string       tag;
    logic [51:0] vec;  // {PCSource, stall, flush, jump_ack, pc_target, taken_count}
  } exp_t;

  logic clk;
  logic rst;
  jump_controller_if #(.PC_WIDTH(PcW)) jif ();

  jump_controller #(
    .PC_WIDTH    (PcW),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(jif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_tgt  = '0;
  logic [15:0] m_cnt  = '0;

  function automatic logic [51:0] observed();
    return {jif.PCSource, jif.stall, jif.flush, jif.jump_ack, jif.pc_target, jif.taken_count};
  endfunction

  function automatic logic [51:0] mk(logic pcs, logic stl, logic fl, logic ack);
    return {pcs, stl, fl, ack, m_tgt, m_cnt};
  endfunction

  task automatic compare(string tag, logic [51:0] exp_v);
    logic [51:0] obs;
    obs = observed();
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Push expectation for the cycle after the next edge, clock, then pop and compare.
  task automatic cyc(string tag, logic pcs, logic stl, logic fl, logic ack);
    exp_t e;
    sb.push_back('{tag: tag, vec: mk(pcs, stl, fl, ack)});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compare(e.tag, e.vec);
  endtask

  task automatic drive(logic req, logic ji, logic jci, logic jcd, logic z, logic busy,
                       logic [31:0] tgt);
    jif.jump_req  = req;
    jif.JumpI     = ji;
    jif.JumpCI    = jci;
    jif.JumpCD    = jcd;
    jif.FlagZ     = z;
    jif.flag_busy = busy;
    jif.target    = tgt;
  endtask

  task automatic jump_taken(string tag, logic ji, logic jci, logic jcd, logic z,
                            logic [31:0] tgt);
    drive(1'b1, ji, jci, jcd, z, 1'b0, tgt);
    m_tgt = tgt;
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    cyc({tag, "_redir"}, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, z, 1'b0, 32'hDEAD_BEEF);
    cyc({tag, "_flush0"}, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc({tag, "_flush1"}, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc({tag, "_idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic jump_not_taken(string tag, logic ji, logic jci, logic jcd, logic z,
                                logic [31:0] tgt);
    drive(1'b1, ji, jci, jcd, z, 1'b0, tgt);
    m_tgt = tgt;
    cyc({tag, "_ack"}, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, z, 1'b0, 32'hDEAD_BEEF);
    cyc({tag, "_idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #12;
    compare("reset_hold", mk(1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) cyc("idle_after_reset", 1'b0, 1'b0, 1'b0, 1'b0);

    // Unconditional jumps, FlagZ irrelevant.
    jump_taken("ji_z0", 1'b1, 1'b0, 1'b0, 1'b0, 32'h40);
    jump_taken("ji_z1", 1'b1, 1'b0, 1'b0, 1'b1, 32'h40);

    // Conditional truth table.
    jump_taken    ("jci_z1", 1'b0, 1'b1, 1'b0, 1'b1, 32'h100);
    jump_not_taken("jci_z0", 1'b0, 1'b1, 1'b0, 1'b0, 32'h104);
    jump_taken    ("jcd_z0", 1'b0, 1'b0, 1'b1, 1'b0, 32'h108);
    jump_not_taken("jcd_z1", 1'b0, 1'b0, 1'b1, 1'b1, 32'h10C);

    // Flag hazard: busy through three edges, Z becomes 1 as busy falls.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200);
    m_tgt = 32'h200;
    for (int i = 0; i < 3; i++) cyc("haz_stall", 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h200);
    m_cnt = m_cnt + 16'd1;
    cyc("haz_redir", 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);  // later FlagZ change must not matter
    cyc("haz_flush0", 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("haz_flush1", 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("haz_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Abort while waiting on the flag.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h300);
    m_tgt = 32'h300;
    cyc("abort_wait", 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h300);
    cyc("abort_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("abort_quiet", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during FLUSH.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h400);
    m_tgt = 32'h400;
    m_cnt = m_cnt + 16'd1;
    cyc("rst_redir", 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc("rst_flush", 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    m_tgt = '0;
    m_cnt = '0;
    #1;
    compare("rst_async", mk(1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b1;
    cyc("rst_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Priority: JumpI beats JumpCD even though JumpCD alone would not be taken.
    jump_taken("prio_ji", 1'b1, 1'b0, 1'b1, 1'b1, 32'h500);
    // No type bits: ack only.
    jump_not_taken("no_type", 1'b0, 1'b0, 1'b0, 1'b0, 32'h600);

    // Saturation: preload near the top, then two taken jumps.
    force dut.taken_count_q = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.taken_count_q;
    m_cnt = 16'hFFFE;
    cyc("sat_preload", 1'b0, 1'b0, 1'b0, 1'b0);
    jump_taken("sat_to_max", 1'b1, 1'b0, 1'b0, 1'b0, 32'h700);
    jump_taken("sat_hold", 1'b0, 1'b1, 1'b0, 1'b1, 32'h704);

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
